// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - operand-tracking reservation station feeding one ALU
// Entries capture CDB results by tag; the lowest-index ready entry issues each cycle.
module reservation_station #(
    parameter int RS_SIZE      = 8,
    parameter int ROB_SIZE_BIT = 4,
    parameter int RS_TYPE_BIT  = 5
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_clear,
    input  logic                    dis_valid,
    input  logic [RS_TYPE_BIT-1:0]  dis_type,
    input  logic [ROB_SIZE_BIT-1:0] dis_rob_id,
    input  logic [31:0]             dis_r1_val,
    input  logic                    dis_r1_dep,
    input  logic [ROB_SIZE_BIT-1:0] dis_r1_rob,
    input  logic [31:0]             dis_r2_val,
    input  logic                    dis_r2_dep,
    input  logic [ROB_SIZE_BIT-1:0] dis_r2_rob,
    output logic                    rs_full,
    input  logic                    cdb_alu_fi,
    input  logic [ROB_SIZE_BIT-1:0] cdb_alu_rob,
    input  logic [31:0]             cdb_alu_val,
    input  logic                    cdb_lsb_fi,
    input  logic [ROB_SIZE_BIT-1:0] cdb_lsb_rob,
    input  logic [31:0]             cdb_lsb_val,
    output logic                    alu_input,
    output logic [RS_TYPE_BIT-1:0]  arith_type,
    output logic [31:0]             r1_val,
    output logic [31:0]             r2_val,
    output logic [ROB_SIZE_BIT-1:0] inst_rob_id
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]      r_busy;
    logic [RS_SIZE-1:0]      r_d1;
    logic [RS_SIZE-1:0]      r_d2;
    logic [RS_TYPE_BIT-1:0]  r_type [RS_SIZE];
    logic [ROB_SIZE_BIT-1:0] r_rob  [RS_SIZE];
    logic [31:0]             r_v1   [RS_SIZE];
    logic [31:0]             r_v2   [RS_SIZE];
    logic [ROB_SIZE_BIT-1:0] r_q1   [RS_SIZE];
    logic [ROB_SIZE_BIT-1:0] r_q2   [RS_SIZE];

    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_ready_idx;
    logic             w_has_ready;
    logic             w_dis_accept;
    logic             w_dis_d1;
    logic             w_dis_d2;
    logic [31:0]      w_dis_v1;
    logic [31:0]      w_dis_v2;

    assign rs_full      = &r_busy;
    assign w_dis_accept = rdy_in && !rob_clear && dis_valid && !rs_full;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_free_idx  = '0;
        w_ready_idx = '0;
        w_has_ready = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = IDX_W'(i);
            end
            if (r_busy[i] && !r_d1[i] && !r_d2[i]) begin
                w_ready_idx = IDX_W'(i);
                w_has_ready = 1'b1;
            end
        end
    end

    // Same-edge bypass for dispatched operands; ALU broadcast wins over LSB.
    always_comb begin
        w_dis_d1 = dis_r1_dep;
        w_dis_v1 = dis_r1_val;
        w_dis_d2 = dis_r2_dep;
        w_dis_v2 = dis_r2_val;
        if (dis_r1_dep) begin
            if (cdb_alu_fi && cdb_alu_rob == dis_r1_rob) begin
                w_dis_d1 = 1'b0;
                w_dis_v1 = cdb_alu_val;
            end else if (cdb_lsb_fi && cdb_lsb_rob == dis_r1_rob) begin
                w_dis_d1 = 1'b0;
                w_dis_v1 = cdb_lsb_val;
            end
        end
        if (dis_r2_dep) begin
            if (cdb_alu_fi && cdb_alu_rob == dis_r2_rob) begin
                w_dis_d2 = 1'b0;
                w_dis_v2 = cdb_alu_val;
            end else if (cdb_lsb_fi && cdb_lsb_rob == dis_r2_rob) begin
                w_dis_d2 = 1'b0;
                w_dis_v2 = cdb_lsb_val;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy      <= '0;
            alu_input   <= 1'b0;
            arith_type  <= '0;
            r1_val      <= '0;
            r2_val      <= '0;
            inst_rob_id <= '0;
        end else if (rdy_in) begin
            if (rob_clear || !w_has_ready) begin
                alu_input   <= 1'b0;
                arith_type  <= '0;
                r1_val      <= '0;
                r2_val      <= '0;
                inst_rob_id <= '0;
            end else begin
                alu_input   <= 1'b1;
                arith_type  <= r_type[w_ready_idx];
                r1_val      <= r_v1[w_ready_idx];
                r2_val      <= r_v2[w_ready_idx];
                inst_rob_id <= r_rob[w_ready_idx];
            end
            if (rob_clear) begin
                r_busy <= '0;
            end else begin
                if (w_has_ready) begin
                    r_busy[w_ready_idx] <= 1'b0;
                end
                if (w_dis_accept) begin
                    r_busy[w_free_idx] <= 1'b1;
                end
            end
        end
    end

    // Payload needs no reset: it is only observed while the matching busy bit is set.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !rob_clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_d1[i]) begin
                    if (cdb_alu_fi && cdb_alu_rob == r_q1[i]) begin
                        r_d1[i] <= 1'b0;
                        r_v1[i] <= cdb_alu_val;
                    end else if (cdb_lsb_fi && cdb_lsb_rob == r_q1[i]) begin
                        r_d1[i] <= 1'b0;
                        r_v1[i] <= cdb_lsb_val;
                    end
                end
                if (r_busy[i] && r_d2[i]) begin
                    if (cdb_alu_fi && cdb_alu_rob == r_q2[i]) begin
                        r_d2[i] <= 1'b0;
                        r_v2[i] <= cdb_alu_val;
                    end else if (cdb_lsb_fi && cdb_lsb_rob == r_q2[i]) begin
                        r_d2[i] <= 1'b0;
                        r_v2[i] <= cdb_lsb_val;
                    end
                end
            end
            if (w_dis_accept) begin
                r_type[w_free_idx] <= dis_type;
                r_rob[w_free_idx]  <= dis_rob_id;
                r_v1[w_free_idx]   <= w_dis_v1;
                r_d1[w_free_idx]   <= w_dis_d1;
                r_q1[w_free_idx]   <= dis_r1_rob;
                r_v2[w_free_idx]   <= w_dis_v2;
                r_d2[w_free_idx]   <= w_dis_d2;
                r_q2[w_free_idx]   <= dis_r2_rob;
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station
// A transaction-level model predicts each edge's issue; a monitor compares at negedge.
module tb_reservation_station;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in, rob_clear, dis_valid;
    logic [4:0]  dis_type;
    logic [3:0]  dis_rob_id, dis_r1_rob, dis_r2_rob;
    logic [31:0] dis_r1_val, dis_r2_val;
    logic        dis_r1_dep, dis_r2_dep;
    logic        rs_full;
    logic        cdb_alu_fi, cdb_lsb_fi;
    logic [3:0]  cdb_alu_rob, cdb_lsb_rob;
    logic [31:0] cdb_alu_val, cdb_lsb_val;
    logic        alu_input;
    logic [4:0]  arith_type;
    logic [31:0] r1_val, r2_val;
    logic [3:0]  inst_rob_id;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .dis_valid(dis_valid), .dis_type(dis_type), .dis_rob_id(dis_rob_id),
        .dis_r1_val(dis_r1_val), .dis_r1_dep(dis_r1_dep), .dis_r1_rob(dis_r1_rob),
        .dis_r2_val(dis_r2_val), .dis_r2_dep(dis_r2_dep), .dis_r2_rob(dis_r2_rob),
        .rs_full(rs_full),
        .cdb_alu_fi(cdb_alu_fi), .cdb_alu_rob(cdb_alu_rob), .cdb_alu_val(cdb_alu_val),
        .cdb_lsb_fi(cdb_lsb_fi), .cdb_lsb_rob(cdb_lsb_rob), .cdb_lsb_val(cdb_lsb_val),
        .alu_input(alu_input), .arith_type(arith_type), .r1_val(r1_val),
        .r2_val(r2_val), .inst_rob_id(inst_rob_id)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          busy;
        logic [4:0]  typ;
        logic [3:0]  rob;
        logic [31:0] v1, v2;
        bit          d1, d2;
        logic [3:0]  q1, q2;
    } ent_t;

    typedef struct packed {
        logic        vld;
        logic [4:0]  typ;
        logic [31:0] r1, r2;
        logic [3:0]  rob;
    } out_t;

    ent_t m[8];
    out_t m_out = '0;
    out_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic bit model_full();
        int cnt = 0;
        foreach (m[i]) if (m[i].busy) cnt++;
        return cnt == 8;
    endfunction

    // Resolve a waiting operand against the broadcasts visible on this edge.
    task automatic snoop(inout bit d, inout logic [31:0] v, input logic [3:0] q);
        if (!d) return;
        if (cdb_alu_fi && cdb_alu_rob == q) begin d = 0; v = cdb_alu_val; end
        else if (cdb_lsb_fi && cdb_lsb_rob == q) begin d = 0; v = cdb_lsb_val; end
    endtask

    task automatic model_clear();
        foreach (m[i]) m[i].busy = 0;
        m_out = '0;
    endtask

    task automatic model_edge();
        int iss = -1;
        int fr = -1;
        bit full;
        ent_t e;
        if (rst_in) begin
            model_clear();
        end else if (rdy_in) begin
            if (rob_clear) begin
                model_clear();
            end else begin
                full = model_full();
                foreach (m[i]) begin
                    if (iss < 0 && m[i].busy && !m[i].d1 && !m[i].d2) iss = i;
                    if (fr < 0 && !m[i].busy) fr = i;
                end
                if (iss >= 0) begin
                    m_out = {1'b1, m[iss].typ, m[iss].v1, m[iss].v2, m[iss].rob};
                    m[iss].busy = 0;
                end else begin
                    m_out = '0;
                end
                foreach (m[i]) begin
                    if (m[i].busy) begin
                        snoop(m[i].d1, m[i].v1, m[i].q1);
                        snoop(m[i].d2, m[i].v2, m[i].q2);
                    end
                end
                if (dis_valid && !full) begin
                    e.busy = 1; e.typ = dis_type; e.rob = dis_rob_id;
                    e.v1 = dis_r1_val; e.d1 = dis_r1_dep; e.q1 = dis_r1_rob;
                    e.v2 = dis_r2_val; e.d2 = dis_r2_dep; e.q2 = dis_r2_rob;
                    snoop(e.d1, e.v1, e.q1);
                    snoop(e.d2, e.v2, e.q2);
                    m[fr] = e;
                end
            end
        end
        exp_q.push_back(m_out);
    endtask

    always @(posedge clk_in) model_edge();

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        out_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("alu_input", 32'(alu_input), 32'(e.vld));
            chk("arith_type", 32'(arith_type), 32'(e.typ));
            chk("r1_val", r1_val, e.r1);
            chk("r2_val", r2_val, e.r2);
            chk("inst_rob_id", 32'(inst_rob_id), 32'(e.rob));
            chk("rs_full", 32'(rs_full), 32'(model_full()));
        end
    end

    task automatic clr();
        rdy_in = 1; rob_clear = 0; dis_valid = 0; dis_type = 0; dis_rob_id = 0;
        dis_r1_val = 0; dis_r1_dep = 0; dis_r1_rob = 0;
        dis_r2_val = 0; dis_r2_dep = 0; dis_r2_rob = 0;
        cdb_alu_fi = 0; cdb_alu_rob = 0; cdb_alu_val = 0;
        cdb_lsb_fi = 0; cdb_lsb_rob = 0; cdb_lsb_val = 0;
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) @(negedge clk_in);
    endtask

    task automatic dis(input logic [4:0] t, input logic [3:0] rob,
                       input logic [31:0] v1, input bit d1, input logic [3:0] q1,
                       input logic [31:0] v2, input bit d2, input logic [3:0] q2);
        dis_valid = 1; dis_type = t; dis_rob_id = rob;
        dis_r1_val = v1; dis_r1_dep = d1; dis_r1_rob = q1;
        dis_r2_val = v2; dis_r2_dep = d2; dis_r2_rob = q2;
    endtask

    task automatic idle(input int n);
        clr();
        step(n);
    endtask

    initial begin
        clr();
        #1;
        chk("reset alu_input", 32'(alu_input), 0);
        chk("reset rs_full", 32'(rs_full), 0);
        step(2);
        rst_in = 0;

        // Ready dispatch
        clr(); dis(5'd0, 4'd3, 32'd5, 0, 0, 32'd7, 0, 0); step();
        idle(4);

        // Dependency wakeup
        clr(); dis(5'd2, 4'd4, 32'd0, 1, 4'd6, 32'd1, 0, 0); step();
        idle(2);
        clr(); cdb_alu_fi = 1; cdb_alu_rob = 6; cdb_alu_val = 32'h10; step();
        idle(3);

        // Same-edge bypass, with a conflicting ALU/LSB broadcast on a second entry
        clr(); dis(5'd4, 4'd5, 32'd9, 0, 0, 32'd0, 1, 4'd2);
        cdb_lsb_fi = 1; cdb_lsb_rob = 2; cdb_lsb_val = 32'hFF; step();
        clr(); dis(5'd6, 4'd7, 32'd0, 1, 4'd1, 32'd3, 0, 0);
        cdb_alu_fi = 1; cdb_alu_rob = 1; cdb_alu_val = 32'hA1;
        cdb_lsb_fi = 1; cdb_lsb_rob = 1; cdb_lsb_val = 32'hB2; step();
        idle(4);

        // Fill all entries waiting on tag 9, then a dropped 9th dispatch
        for (int i = 0; i < 8; i++) begin
            clr(); dis(5'(i), 4'(i), 32'd0, 1, 4'd9, 32'(100 + i), 0, 0); step();
        end
        clr(); dis(5'd31, 4'd15, 32'd1, 0, 0, 32'd2, 0, 0); step();
        clr(); cdb_alu_fi = 1; cdb_alu_rob = 9; cdb_alu_val = 32'h99; step();
        idle(10);

        // Freeze with pending work, then flush
        clr(); dis(5'd1, 4'd10, 32'd11, 0, 0, 32'd12, 0, 0); step();
        clr(); dis(5'd3, 4'd11, 32'd13, 0, 0, 32'd14, 0, 0); step();
        clr(); rdy_in = 0; dis(5'd5, 4'd12, 32'd1, 0, 0, 32'd1, 0, 0);
        cdb_alu_fi = 1; cdb_alu_rob = 0; cdb_alu_val = 32'h55; step(3);
        clr(); rob_clear = 1; dis(5'd7, 4'd13, 32'd2, 0, 0, 32'd2, 0, 0); step();
        idle(4);

        // Asynchronous reset while entries are busy and an issue is on the outputs
        clr(); dis(5'd8, 4'd1, 32'd21, 0, 0, 32'd22, 0, 0); step();
        clr(); dis(5'd9, 4'd2, 32'd0, 1, 4'd5, 32'd23, 0, 0); step();
        clr();
        #2 rst_in = 1;
        model_clear();
        #1;
        chk("async alu_input", 32'(alu_input), 0);
        chk("async r1_val", r1_val, 0);
        chk("async inst_rob_id", 32'(inst_rob_id), 0);
        step(2);
        rst_in = 0;
        clr(); dis(5'd10, 4'd6, 32'd31, 0, 0, 32'd32, 0, 0); step();
        idle(4);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            clr();
            rdy_in = ($urandom % 8) != 0;
            rob_clear = ($urandom % 64) == 0;
            if ($urandom % 2)
                dis(5'($urandom), 4'($urandom), $urandom, 1'($urandom), 4'($urandom % 4),
                    $urandom, 1'($urandom), 4'($urandom % 4));
            cdb_alu_fi = ($urandom % 3) == 0; cdb_alu_rob = 4'($urandom % 4);
            cdb_alu_val = $urandom;
            cdb_lsb_fi = ($urandom % 3) == 0; cdb_lsb_rob = 4'($urandom % 4);
            cdb_lsb_val = $urandom;
            step();
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
